// File: rtl/ram4_scan16_if.sv
// Write/read bus for the four-entry register bank. The bench drives the master side.
// The bank connects to the slave side.
interface ram4_scan16_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] i_in;
  logic             i_load;
  logic [1:0]       i_address;
  logic             i_scan_en;
  logic [WIDTH-1:0] o_q0, o_q1, o_q2, o_q3;
  logic [1:0]       o_sel;
  logic [WIDTH-1:0] o_out;
  logic             o_wrap;

  modport master (
    output i_in, i_load, i_address, i_scan_en,
    input  o_q0, o_q1, o_q2, o_q3, o_sel, o_out, o_wrap
  );
  modport slave (
    input  i_in, i_load, i_address, i_scan_en,
    output o_q0, o_q1, o_q2, o_q3, o_sel, o_out, o_wrap
  );
endinterface

// File: rtl/ram4_scan16.sv
// Four 16-bit registers that feed a Mux4Way16. The mux select comes either from the
// write address or from a free-running 2-bit scan counter.
module Mux4Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);
  always_comb begin
    out = a;
    unique case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end
endmodule

module ram4_scan16 #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  ram4_scan16_if.slave bus
);
  logic [3:0][WIDTH-1:0] r_mem;
  logic [1:0]            r_cnt;
  logic                  r_wrap;
  logic [1:0]            w_sel;
  logic [WIDTH-1:0]      w_out;

  for (genvar g = 0; g < 4; g++) begin : g_ent
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         r_mem[g] <= '0;
      else if (bus.i_load && bus.i_address == 2'(g))   r_mem[g] <= bus.i_in;
    end
  end

  // The counter only holds when the block leaves scan mode. It is not cleared, so
  // scanning resumes where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= bus.i_scan_en && (r_cnt == 2'd3);
      if (bus.i_scan_en) r_cnt <= r_cnt + 2'd1;
    end
  end

  assign w_sel = bus.i_scan_en ? r_cnt : bus.i_address;

  Mux4Way16 u_mux (
    .a   (r_mem[0]),
    .b   (r_mem[1]),
    .c   (r_mem[2]),
    .d   (r_mem[3]),
    .sel (w_sel),
    .out (w_out)
  );

  assign bus.o_q0   = r_mem[0];
  assign bus.o_q1   = r_mem[1];
  assign bus.o_q2   = r_mem[2];
  assign bus.o_q3   = r_mem[3];
  assign bus.o_sel  = w_sel;
  assign bus.o_out  = w_out;
  assign bus.o_wrap = r_wrap;
endmodule

// File: doc/ram4_scan16.md
Name: ram4_scan16

Overview:
- Bank of four 16-bit registers. It sits directly upstream of the 4-way 16-bit multiplexer stage and drives that mux's four data inputs and its 2-bit select.
- Registers are written one at a time through an address/load port.
- Select comes from the write address (direct mode) or from an internal wrapping counter that walks the four entries (scan mode).
- Read data is produced by an internal instance of the team's 4-way 16-bit mux, so the mux is exercised by a real sequential source.

Parameters:
- WIDTH, 16, data width of each register. Fixed at 16 for this block; the parameter exists for bench readability only.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in  input  16  write data
- load  input  1  write enable; writes in to entry address on rising clk
- address  input  2  write target; also the read select in direct mode
- scan_en  input  1  1 = scan mode (select from counter), 0 = direct mode
- q0  output  16  entry 0 contents (to mux input a)
- q1  output  16  entry 1 contents (to mux input b)
- q2  output  16  entry 2 contents (to mux input c)
- q3  output  16  entry 3 contents (to mux input d)
- sel  output  2  effective select (to mux sel)
- out  output  16  contents of entry sel, via the internal Mux4Way16
- wrap  output  1  one-cycle pulse when the scan counter rolls 3 -> 0

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately without a clock edge):
  - q0..q3 = 16'h0000
  - scan counter = 0
  - wrap = 0
  - sel = address if scan_en=0, else 0
  - out = 16'h0000
- Reset held: all state stays at reset values and load is ignored.
- Release: state updates resume on the first rising clk where rst=0.
- Write: on rising clk with load=1, entry[address] <= in. Latency 1 cycle. The other entries are unchanged.
- Read: out is combinational from the stored entries and sel. It shows stored values only, never in.
  - A write to the entry currently selected is visible on out right after the edge, not before it.
- Scan counter, 2-bit:
  - On rising clk with scan_en=1: cnt <= cnt+1, wrapping 3 -> 0.
  - With scan_en=0: cnt holds its value; it is not cleared.
- sel = scan_en ? cnt : address. Combinational, so a mode switch takes effect the same cycle.
- wrap: registered. It is set to 1 on the edge where scan_en=1 and cnt==3 (cnt becomes 0); otherwise 0.
- Simultaneous write and scan are independent:
  - The write uses address.
  - The counter advances.
  - out after the edge reflects both the new cnt and any new entry value.
- Write to entry X while scanning past X in the same cycle: after the edge, entry X holds the new data; the counter has moved on.
- Reset mid-scan or mid-write: asynchronous clear wins, any pending write is dropped, and cnt returns to 0.
- X/Z on address with load=1 is illegal. The bench must not drive it.
- Implementation:
  - Four 16-bit registers.
  - A 2-bit counter.
  - A wrap flop.
  - A select mux.
  - An instance of the team's 4-way 16-bit mux, reusing its module name and port order (a, b, c, d, sel, out).

Test Plan:
- Reset: pulse rst between clock edges after loading nonzero data -> q0..q3=0000 and out=0000 immediately; wrap=0.
- Direct write/read:
  - load=1, address=1, in=16'h0730, one edge -> q1=0730.
  - Then load=0, address=1, scan_en=0 -> sel=1, out=0730; q0/q2/q3 stay 0000.
- Read-before-write:
  - address=2, load=1, in=16'h0010 -> before the edge out=0000, after the edge out=0010.
- Scan wrap:
  - Preload entries to a211, 0003, 0010, 1000.
  - scan_en=1 for 5 edges -> out sequence a211, 0003, 0010, 1000, a211, and sel 0, 1, 2, 3, 0.
  - wrap=1 for exactly the cycle after the 3 -> 0 edge.
- Mode switch and hold:
  - In scan at cnt=2, drop scan_en with address=3 -> same cycle sel=3, out=1000.
  - Re-enable scan after 3 idle edges -> sel=2 (counter held).
- Concurrent write during scan:
  - cnt=0, scan_en=1, load=1, address=1, in=16'h0090 -> after the edge sel=1, out=0090.
  - Assert rst mid-sequence -> all entries and cnt cleared without a clock edge.
